// File: rtl/perf_counter_multi_if.sv
// rtl/perf_counter_multi_if.sv - Avalon-MM control slave bus bundle for perf_counter_multi
interface perf_counter_multi_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              begintransfer;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address, begintransfer, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, begintransfer, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/perf_counter_multi.sv
// rtl/perf_counter_multi.sv - multi-section time/event performance counter with coherent 64-bit reads
module perf_counter_multi #(
  parameter int NUM_SECTIONS = 4,
  parameter int ADDR_W       = 4,
  parameter int TIME_W       = 64,
  parameter int EVENT_W      = 32,
  parameter bit SATURATE     = 1'b0,
  parameter bit EVENT_SRC    = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  perf_counter_multi_if.slave     bus,
  input  logic [NUM_SECTIONS-1:0] event_in
);

  // Section index is everything above the two offset bits; one extra bit of
  // headroom keeps the width legal even for the smallest address map.
  localparam int SEC_W = ADDR_W - 1;

  logic [SEC_W-1:0] sec_idx;
  logic [1:0]       off;
  logic             wr_stb;
  logic             rd_stb;
  logic             sec0_hit;
  logic             greset;
  logic             start_0;
  logic             genable;
  logic             unused_wdata;

  logic [NUM_SECTIONS-1:0]       run_vec;
  logic [NUM_SECTIONS-1:0][31:0] sec_word;
  logic [31:0]                   rd_mux;

  assign sec_idx  = SEC_W'(bus.address >> 2);
  assign off      = bus.address[1:0];
  assign wr_stb   = bus.write & bus.begintransfer;
  assign rd_stb   = bus.read & bus.begintransfer;
  assign sec0_hit = (sec_idx == '0);

  // Section 0 doubles as the global control: a stop with bit 0 set resets
  // everything, and nothing counts unless section 0 runs or is being started.
  assign greset  = wr_stb & sec0_hit & (off == 2'd0) & bus.writedata[0];
  assign start_0 = wr_stb & sec0_hit & (off == 2'd1);
  assign genable = run_vec[0] | start_0;

  // Only the two control bits of writedata carry meaning.
  assign unused_wdata = ^bus.writedata[31:2];

  for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_sec
    localparam logic [SEC_W-1:0] SID = SEC_W'(s);

    logic               hit;
    logic               stop_s;
    logic               start_s;
    logic               ctl_s;
    logic               lo_rd_s;
    logic               clr_cnt;
    logic               clr_flag;
    logic               t_inc;
    logic               e_inc;
    logic               t_max;
    logic               e_max;
    logic               run_q;
    logic               tovf_q;
    logic               eovf_q;
    logic [TIME_W-1:0]  time_q;
    logic [EVENT_W-1:0] evt_q;
    logic [31:0]        hi_q;
    logic [63:0]        time_ext;
    logic [31:0]        word;

    assign hit      = (sec_idx == SID);
    assign stop_s   = wr_stb & hit & (off == 2'd0);
    assign start_s  = wr_stb & hit & (off == 2'd1);
    assign ctl_s    = wr_stb & hit & (off == 2'd3);
    assign lo_rd_s  = rd_stb & hit & (off == 2'd0);
    assign clr_cnt  = greset | (ctl_s & bus.writedata[0]);
    assign clr_flag = greset | (ctl_s & bus.writedata[1]);
    assign t_inc    = run_q & genable;
    assign e_inc    = (EVENT_SRC ? (event_in[s] & run_q) : start_s) & genable;
    assign t_max    = &time_q;
    assign e_max    = &evt_q;
    assign time_ext = 64'(time_q);
    assign run_vec[s] = run_q;

    // Run bit: stop (or global reset) beats start; otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        run_q <= 1'b0;
      end else if (greset | stop_s) begin
        run_q <= 1'b0;
      end else if (start_s) begin
        run_q <= 1'b1;
      end
    end

    // Time counter: clear beats count; all-ones either wraps naturally or holds.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        time_q <= '0;
      end else if (clr_cnt) begin
        time_q <= '0;
      end else if (t_inc) begin
        if (t_max && SATURATE) begin
          time_q <= time_q;
        end else begin
          time_q <= time_q + TIME_W'(1);
        end
      end
    end

    // Event counter: same clear and overflow behaviour as the time counter.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        evt_q <= '0;
      end else if (clr_cnt) begin
        evt_q <= '0;
      end else if (e_inc) begin
        if (e_max && SATURATE) begin
          evt_q <= evt_q;
        end else begin
          evt_q <= evt_q + EVENT_W'(1);
        end
      end
    end

    // Sticky overflow flags; a clear in the same cycle as an overflow wins.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tovf_q <= 1'b0;
        eovf_q <= 1'b0;
      end else if (clr_flag) begin
        tovf_q <= 1'b0;
        eovf_q <= 1'b0;
      end else begin
        if (t_inc & t_max) tovf_q <= 1'b1;
        if (e_inc & e_max) eovf_q <= 1'b1;
      end
    end

    // High-word snapshot taken on the low-word read edge so both halves match.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hi_q <= '0;
      end else if (greset) begin
        hi_q <= '0;
      end else if (lo_rd_s) begin
        hi_q <= time_ext[63:32];
      end
    end

    // Per-section read word selected by the offset bits.
    always_comb begin
      word = '0;
      case (off)
        2'd0:    word = time_ext[31:0];
        2'd1:    word = hi_q;
        2'd2:    word = 32'(evt_q);
        default: word = {29'b0, eovf_q, tovf_q, run_q};
      endcase
    end

    assign sec_word[s] = word;
  end

  // Section select; unmapped sections fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      if (sec_idx == SEC_W'(i)) rd_mux = sec_word[i];
    end
  end

  // Read data is registered every cycle from the pre-update counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_mux;
    end
  end

endmodule
